// File: rtl/debouncer_multi.sv
// -----------------------------------------------------------------------------
// debouncer_multi
// Multi-channel push-switch debouncer with a shared sample-tick divider.
// Each raw input is synchronised through two flops. A shared divider produces a
// one-clk sample strobe every TICK_DIV clocks. On every strobe, each channel
// compares its synchronised sample with its debounced level. The channel
// accepts a change only after STABLE_CNT consecutive differing samples.
//
// Optional feature (macro DEBOUNCER_MULTI_REPEAT_EN):
//   While a channel is held, an auto-repeat press pulse is issued REPEAT_DLY
//   ticks after the accepted press, and then every REPEAT_PER ticks until the
//   release is accepted. When the macro is undefined, no hold counters exist.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   in     in   [N_CH] raw switch inputs (1 = pressed)
//   level  out  [N_CH] debounced switch state
//   press  out  [N_CH] one-clk pulse on accepted press (and auto-repeat)
//   rel    out  [N_CH] one-clk pulse on accepted release
//   tick   out  sample strobe, exported for debug
// -----------------------------------------------------------------------------
module debouncer_multi #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 3,
    parameter int REPEAT_DLY = 10,
    parameter int REPEAT_PER = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel,
    output logic            tick
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    // Reject out-of-range configurations at elaboration time.
    if (N_CH < 1 || N_CH > 32 || TICK_DIV < 1 || STABLE_CNT < 1 || STABLE_CNT > 255 ||
        REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("debouncer_multi: parameter out of range");
    end

    logic [N_CH-1:0]         sync1_q;
    logic [N_CH-1:0]         sync2_q;
    logic [DW-1:0]           div_q, div_d;
    logic                    tick_q, tick_d;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]         level_q, level_d;
    logic [N_CH-1:0]         press_q, press_d;
    logic [N_CH-1:0]         rel_q, rel_d;

`ifdef DEBOUNCER_MULTI_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PER);

    // Ticks remaining until the next auto-repeat pulse; zero while released.
    logic [N_CH-1:0][RW-1:0] rpt_q, rpt_d;
`endif

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign tick  = tick_q;

    // Two-flop synchroniser for the raw asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    // Shared divider next state; tick is registered so it is high exactly
    // while the divider sits at its last count.
    always_comb begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
        tick_d = (div_d == DIV_LAST);
    end

    // Divider and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // Per-channel stability counting, level toggling and pulse generation.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
`ifdef DEBOUNCER_MULTI_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    // Enough consecutive differing samples: accept the change.
                    cnt_d[i]   = '0;
                    level_d[i] = ~level_q[i];
                    press_d[i] = ~level_q[i];
                    rel_d[i]   = level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
`ifdef DEBOUNCER_MULTI_REPEAT_EN
            if (tick_q) begin
                if (!level_d[i]) begin
                    rpt_d[i] = '0;
                end else if (!level_q[i]) begin
                    // Fresh press: arm the initial repeat delay.
                    rpt_d[i] = RPT_DLY;
                end else if (rpt_q[i] == RW'(1)) begin
                    press_d[i] = 1'b1;
                    rpt_d[i]   = RPT_PER;
                end else begin
                    rpt_d[i] = rpt_q[i] - RW'(1);
                end
            end else begin
                rpt_d[i] = rpt_q[i];
            end
`endif
        end
    end

    // Channel state and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef DEBOUNCER_MULTI_REPEAT_EN
    // Auto-repeat hold counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// -----------------------------------------------------------------------------
// tb_debouncer_multi
// Self-checking bench for debouncer_multi. A behavioural model tracks, per
// channel, how many consecutive sample ticks have disagreed with the debounced
// level and how many ticks a press has been held. Each test task drives
// stimulus, advances the model one clock at a time, and compares outputs.
// Auto-repeat expectations follow the DEBOUNCER_MULTI_REPEAT_EN macro.
// -----------------------------------------------------------------------------
module tb_debouncer_multi;

    localparam int N_CH = 4;
    localparam int TD   = 4;
    localparam int SC   = 3;
    localparam int RD   = 5;
    localparam int RP   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] in  = '0;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic            tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debouncer_multi #(
        .N_CH      (N_CH),
        .TICK_DIV  (TD),
        .STABLE_CNT(SC),
        .REPEAT_DLY(RD),
        .REPEAT_PER(RP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .level(level),
        .press(press),
        .rel  (rel),
        .tick (tick)
    );

    // ---------------- behavioural model ----------------
    int              m_e;            // clock edges since reset release
    logic [N_CH-1:0] m_q1, m_q2;     // input seen one and two edges ago
    logic [N_CH-1:0] m_level, m_press, m_rel;
    logic            m_tick;
    int              m_run  [N_CH];  // consecutive differing samples
    int              m_held [N_CH];  // ticks since accepted press

    task automatic model_reset();
        m_e = 0; m_q1 = '0; m_q2 = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_tick = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_run[i] = 0; m_held[i] = 0;
        end
    endtask

    // Advance DUT and model by one clock; returns at the following negedge.
    task automatic step();
        logic sample_now;
        @(posedge clk);
        m_e++;
        sample_now = (m_e >= 2) && (((m_e - 1) % TD) == TD - 1);
        m_press = '0;
        m_rel   = '0;
        if (sample_now) begin
            for (int i = 0; i < N_CH; i++) begin
                if (m_q2[i] == m_level[i]) m_run[i] = 0;
                else                       m_run[i] = m_run[i] + 1;
                if (m_run[i] == SC) begin
                    m_run[i]   = 0;
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        m_held[i]  = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end else if (m_level[i]) begin
                    m_held[i] = m_held[i] + 1;
`ifdef DEBOUNCER_MULTI_REPEAT_EN
                    if (m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) m_press[i] = 1'b1;
`endif
                end
            end
        end
        m_q2   = m_q1;
        m_q1   = in;
        m_tick = ((m_e % TD) == TD - 1);
        @(negedge clk);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        checks++;
        if ({level, press, rel, tick} !== '0) begin
            errors++;
            $display("FAIL reset_state: got l=%h p=%h r=%h t=%b, want all 0", level, press, rel, tick);
        end
        release_reset();
        repeat (8) begin
            step();
            checks++;
            if ({level, press, rel, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL reset_idle: got l=%h p=%h r=%h t=%b, want l=%h p=%h r=%h t=%b",
                         level, press, rel, tick, m_level, m_press, m_rel, m_tick);
            end
        end
    endtask

    task automatic test_single_press();
        int npress = 0, nrel = 0, lat = -1;
        repeat ($urandom_range(0, 3)) step();
        in[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if ({level, press, rel, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL single_model: got l=%h p=%h r=%h, want l=%h p=%h r=%h",
                         level, press, rel, m_level, m_press, m_rel);
            end
            if (press[0]) begin
                npress++;
                if (lat < 0) lat = k;
            end
            if (rel[0]) nrel++;
        end
        checks++;
        if (npress != 1) begin errors++; $display("FAIL single_press_count: got %0d want 1", npress); end
        checks++;
        if (nrel != 0) begin errors++; $display("FAIL single_rel_count: got %0d want 0", nrel); end
        checks++;
        if (lat < 9 || lat > 14) begin errors++; $display("FAIL single_latency: got %0d want 9..14", lat); end
        checks++;
        if (level[0] !== 1'b1) begin errors++; $display("FAIL single_level: got %b want 1", level[0]); end
        in[0] = 1'b0;
        repeat (20) step();
        checks++;
        if (level !== '0) begin errors++; $display("FAIL single_released: got %h want 0", level); end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        in[1] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (k == 6) in[1] = 1'b0;
            step();
            seen = seen | level[1] | press[1] | rel[1];
            checks++;
            if ({level, press, rel, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL glitch_model: got l=%h p=%h r=%h, want l=%h p=%h r=%h",
                         level, press, rel, m_level, m_press, m_rel);
            end
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch_ch1: got activity=1 want 0"); end
    endtask

    task automatic test_simultaneous();
        int k;
        in = 4'hF;
        k = 0;
        while (press === 4'h0 && k < 24) begin step(); k++; end
        checks++;
        if (press !== 4'hF) begin errors++; $display("FAIL simul_press: got %h want f", press); end
        checks++;
        if (level !== 4'hF) begin errors++; $display("FAIL simul_level: got %h want f", level); end
        in = 4'h0;
        k = 0;
        step();
        while (rel === 4'h0 && k < 24) begin step(); k++; end
        checks++;
        if (rel !== 4'hF) begin errors++; $display("FAIL simul_rel: got %h want f", rel); end
        step();
        checks++;
        if ({level, press, rel} !== '0) begin
            errors++;
            $display("FAIL simul_idle: got l=%h p=%h r=%h want 0", level, press, rel);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, lat = -1;
        in[2] = 1'b1;
        while (m_run[2] < 2 && k < 24) begin step(); k++; end
        checks++;
        if (m_run[2] != 2 || level[2] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_setup: got run=%0d level=%b want 2/0", m_run[2], level[2]);
        end
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({level, press, rel, tick} !== '0) begin
            errors++;
            $display("FAIL midrst_clear: got l=%h p=%h r=%h t=%b want 0", level, press, rel, tick);
        end
        release_reset();
        for (int j = 1; j <= 20; j++) begin
            step();
            checks++;
            if ({level, press, rel, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL midrst_model: got l=%h p=%h r=%h t=%b, want l=%h p=%h r=%h t=%b",
                         level, press, rel, tick, m_level, m_press, m_rel, m_tick);
            end
            if (press[2] && lat < 0) lat = j;
        end
        checks++;
        if (lat != 3 * TD) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, 3 * TD); end
        in[2] = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_repeat();
        int npress = 0, want;
`ifdef DEBOUNCER_MULTI_REPEAT_EN
        want = 19;
`else
        want = 1;
`endif
        in[0] = 1'b1;
        for (int k = 0; k < 40 * TD + 8 * TD; k++) begin
            if (k == 40 * TD) in[0] = 1'b0;
            step();
            if (press[0]) npress++;
            checks++;
            if ({level, press, rel} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL repeat_model: got l=%h p=%h r=%h, want l=%h p=%h r=%h",
                         level, press, rel, m_level, m_press, m_rel);
            end
        end
        checks++;
        if (npress != want) begin errors++; $display("FAIL repeat_count: got %0d want %0d", npress, want); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 7) == 0) in[i] = ~in[i];
            end
            step();
            checks++;
            if ({level, press, rel, tick} !== {m_level, m_press, m_rel, m_tick}) begin
                errors++;
                $display("FAIL random_model: got l=%h p=%h r=%h t=%b, want l=%h p=%h r=%h t=%b",
                         level, press, rel, tick, m_level, m_press, m_rel, m_tick);
            end
            checks++;
            if ((press & rel) !== '0) begin
                errors++;
                $display("FAIL random_press_rel: got overlap %h want 0", press & rel);
            end
        end
        in = '0;
        repeat (20) step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
